// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// baud-setup limits.
package uart_pkg;

    localparam int DEF_SETUP_W = 24;
    localparam int MIN_SETUP   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; flops reset to
// RESET_VAL so an idle-high line looks idle straight out of reset.
module uart_bit_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: mid-bit sampling with one baud down-counter, start-glitch
// rejection, frame-error flag and break detection.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int SETUP_W     = DEF_SETUP_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [SETUP_W-1:0] i_setup,
    input  logic               i_uart_rx,
    output logic               o_wr,
    output logic [7:0]         o_data,
    output logic               o_frame_err,
    output logic               o_break
);

    rx_state_t          state_q;
    logic [SETUP_W-1:0] cnt_q;
    logic [SETUP_W-1:0] baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               line;
    logic [SETUP_W-1:0] setup_c;

    function automatic logic [SETUP_W-1:0] clamp_setup(input logic [SETUP_W-1:0] s);
        if (s < SETUP_W'(MIN_SETUP)) begin
            return SETUP_W'(MIN_SETUP);
        end
        return s;
    endfunction

    function automatic logic [SETUP_W-1:0] half_bit(input logic [SETUP_W-1:0] b);
        return (b >> 1) - SETUP_W'(1);
    endfunction

    uart_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_uart_rx),
        .o_q       (line)
    );

    assign setup_c = clamp_setup(i_setup);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            o_wr        <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_break     <= 1'b0;
        end else begin
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!line) begin
                        state_q <= ST_START;
                        cnt_q   <= half_bit(setup_c);
                    end
                end
                ST_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - SETUP_W'(1);
                    end else if (!line) begin
                        state_q   <= ST_DATA;
                        cnt_q     <= baud_q - SETUP_W'(1);
                        bit_idx_q <= '0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_q <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - SETUP_W'(1);
                    end else begin
                        cnt_q     <= baud_q - SETUP_W'(1);
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - SETUP_W'(1);
                    end else begin
                        o_data      <= shift_q;
                        o_wr        <= 1'b1;
                        o_frame_err <= ~line;
                        if (line) begin
                            state_q <= ST_IDLE;
                        end else begin
                            // Only an all-zero frame with a zero stop bit is a true break.
                            state_q <= ST_BREAK;
                            o_break <= (shift_q == 8'h00);
                        end
                    end
                end
                ST_BREAK: begin
                    if (line) begin
                        state_q <= ST_IDLE;
                        o_break <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers: baud latched at frame start, LSB-first shift at each data mid-bit.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_IDLE && !line) begin
            baud_q <= setup_c;
        end
        if (state_q == ST_DATA && cnt_q == '0) begin
            shift_q <= {line, shift_q[7:1]};
        end
    end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL provide parameter SETUP_W, default 24: width of the clocks-per-baud input.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: flop count of the rx input synchronizer, minimum 2.
REQ-003 SHALL provide port i_clk, input, 1: single system clock; all logic in this one domain.
REQ-004 SHALL provide port i_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL provide port i_setup, input, SETUP_W: clocks per baud period.
REQ-006 SHALL provide port i_uart_rx, input, 1: asynchronous serial line, idle high, 8N1.
REQ-007 SHALL provide port o_wr, output, 1: one-cycle strobe, received byte valid; feeds wbuart rx_stb.
REQ-008 SHALL provide port o_data, output, 8: received byte, held stable until next o_wr; feeds wbuart rx_uart_data.
REQ-009 SHALL provide port o_frame_err, output, 1: qualifies o_wr; high when the stop bit sampled 0.
REQ-010 SHALL provide port o_break, output, 1: level; line held in break condition.

Function
REQ-011 SHALL pass i_uart_rx through a SYNC_STAGES-flop synchronizer before any use; "line" below means the synchronized value.
REQ-012 SHALL latch i_setup into a baud register on IDLE->START; changes to i_setup mid-frame SHALL have no effect until the next frame.
REQ-013 SHALL clamp a latched setup value below 16 to 16.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK with one down-counter of SETUP_W bits and a 3-bit bit index.
REQ-015 In IDLE, line = 0 SHALL move to START with counter loaded to baud/2 - 1 (half-bit, integer division).
REQ-016 In START, counter = 0 and line = 0 SHALL move to DATA with counter = baud - 1 and bit index 0; counter = 0 and line = 1 SHALL return to IDLE with no output (glitch reject).
REQ-017 In DATA, each counter = 0 SHALL sample line into the shift register LSB-first, reload baud - 1, and increment the bit index; the sample at bit index 7 SHALL move to STOP.
REQ-018 In STOP, counter = 0 SHALL load o_data from the shift register, assert o_wr for exactly one cycle, and set o_frame_err = ~line in that same cycle.
REQ-019 o_wr latency SHALL be exactly one clock after the stop-bit mid-sample edge.
REQ-020 After STOP: line = 1 SHALL go to IDLE; line = 0 SHALL go to BREAK.
REQ-021 BREAK SHALL assert o_break only if the frame just completed had data 0x00 and stop = 0; otherwise o_break SHALL stay 0.
REQ-022 BREAK SHALL hold without re-arming until line = 1, then clear o_break and go to IDLE on the next clock.
REQ-023 A start edge arriving on the first IDLE cycle after STOP SHALL be accepted, so back-to-back frames are not lost.
REQ-024 o_frame_err SHALL be meaningful only while o_wr = 1 and SHALL be 0 otherwise.

Reset
REQ-025 While i_reset_n = 0: state = IDLE, o_wr = 0, o_data = 0x00, o_frame_err = 0, o_break = 0, counter = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no o_wr pulse, either during reset or after release.
REQ-027 After reset release, a line already low SHALL be treated as a start edge only after the synchronizer shows a 1 followed by a 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum, MIN_SETUP = 16, and the default SETUP_W.
REQ-029 The synchronizer SHALL be a sub-module, uart_bit_sync, parameterized by SYNC_STAGES with a reset value of 1.
REQ-030 All remaining logic SHALL live in uart_rx_frontend; target size 120-400 lines of RTL.

Verification
REQ-031 setup = 16, send 0x55 -> exactly one o_wr, o_data = 0x55, o_frame_err = 0, o_wr one clock after the stop mid-sample.
REQ-032 setup = 16, line low for 4 clocks then high -> no o_wr; the next valid frame 0x3C is received correctly.
REQ-033 setup = 16, send 0xA5 with stop = 0, then line high -> one o_wr, o_data = 0xA5, o_frame_err = 1, o_break = 0.
REQ-034 setup = 16, line low for 20 bit times -> one o_wr with o_data = 0x00 and o_frame_err = 1; o_break high until line high + SYNC_STAGES + 1 clocks; no further o_wr.
REQ-035 setup = 5 (clamped to 16), send 0x10 then 0xFE back-to-back with no idle gap -> two o_wr pulses, data 0x10 then 0xFE, both o_frame_err = 0.
REQ-036 Assert reset mid-DATA of 0xBD -> no o_wr; all outputs at reset values; a following frame 0x98 is received correctly.
